bin_to_bcd_seq: RTL

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_pkg.sv | 23 ++
 rtl/bcd_add3.sv | 12 +
 rtl/bin_to_bcd_seq.sv | 93 +++++++++
 3 files changed

// File: rtl/bin_to_bcd_pkg.sv
// Shared widths, limits and FSM state encoding for the sequential
// binary-to-BCD converter.
package bin_to_bcd_pkg;

  localparam int BIN_W      = 14;
  localparam int BCD_DIGITS = 4;
  localparam int ACC_DIGITS = 5;
  localparam int MAX_DISP   = 9999;

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int ACC_W = 4 * ACC_DIGITS;
  localparam int CNT_W = 4;

  // Counter value loaded on accept; SHIFT runs from here down to 0.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more so
// that the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-and-add-3).
// Optional build macro BIN_TO_BCD_SAT_EN saturates bcd to 9999 on overflow.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [BIN_W-1:0] bin,
  output logic             in_ready,
  output logic             out_valid,
  output logic [BCD_W-1:0] bcd,
  output logic             ovf
);

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_SHIFT = S_SHIFT;
  localparam logic [1:0] ST_DONE  = S_DONE;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] sreg;
  logic [ACC_W-1:0] acc;

  logic [ACC_W-1:0] acc_adj;
  logic [ACC_W-1:0] acc_nxt;
  logic [BIN_W-1:0] sreg_nxt;
  logic             ovf_nxt;
  logic [BCD_W-1:0] bcd_nxt;

  for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (acc[4*g +: 4]),
      .dout (acc_adj[4*g +: 4])
    );
  end

  assign {acc_nxt, sreg_nxt} = {acc_adj, sreg} << 1;

  // acc_nxt is the finished accumulator when the counter reaches 0.
  always_comb begin
    ovf_nxt = (acc_nxt[ACC_W-1 -: 4] != 4'd0);
`ifdef BIN_TO_BCD_SAT_EN
    bcd_nxt = ovf_nxt ? 16'h9999 : acc_nxt[BCD_W-1:0];
`else
    bcd_nxt = acc_nxt[BCD_W-1:0];
`endif
  end

  assign in_ready = (state == ST_IDLE);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sreg      <= '0;
      acc       <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sreg  <= bin;
            acc   <= '0;
            cnt   <= LAST_BIT;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc  <= acc_nxt;
          sreg <= sreg_nxt;
          if (cnt == '0) begin
            // Result and pulse land together, so out_valid coincides with DONE.
            bcd       <= bcd_nxt;
            ovf       <= ovf_nxt;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
